mac_acc: RTL and testbench

Accumulator stage that sits directly downstream of the MULT_FOR combinational multiplier. It consumes the multiplier's 2N-bit products through a valid/ready handshake and sums a frame of len products. It presents the frame total, with a sticky overflow flag, through a second valid/ready handshake. Together with MULT_FOR it forms the dot-product datapath.

---
 rtl/mac_acc.sv | 118 +++++++++++
 tb/tb_mac_acc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mac_acc.sv
// Frame accumulator placed after the MULT_FOR multiplier: it sums len unsigned products per frame.
// The total saturates at all ones and carries a sticky overflow flag; both handshakes are valid/ready.
module mac_acc #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N+8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [CNT_W-1:0]   len,
    input  logic               prod_vld,
    input  logic [2*N-1:0]     prod,
    output logic               prod_rdy,
    output logic               sum_vld,
    output logic [ACC_W-1:0]   sum,
    output logic               ovf,
    input  logic               sum_rdy
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_lenLat;
    logic               r_ovf;
    logic               r_prodRdy;

    logic               w_beat;
    logic [CNT_W-1:0]   w_lenEff;
    logic [CNT_W-1:0]   w_cntInc;
    logic [ACC_W-1:0]   w_prodExt;
    logic [ACC_W:0]     w_addFull;

    assign w_beat    = prod_vld & r_prodRdy;
    assign w_lenEff  = (len == '0) ? CNT_W'(1) : len;
    assign w_cntInc  = r_cnt + CNT_W'(1);
    assign w_prodExt = ACC_W'(prod);
    assign w_addFull = {1'b0, r_acc} + {1'b0, w_prodExt};

    assign prod_rdy = r_prodRdy;
    assign sum_vld  = (r_state == DONE);
    assign sum      = r_acc;
    assign ovf      = r_ovf;

    always_comb begin
        w_nextState = r_state;
        if (clr) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_beat) begin
                        w_nextState = (w_lenEff == CNT_W'(1)) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (w_beat && (w_cntInc == r_lenLat)) begin
                        w_nextState = DONE;
                    end
                end
                DONE: begin
                    if (sum_rdy) begin
                        w_nextState = IDLE;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // prod_rdy is registered from the next state so it never depends combinationally on the handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_prodRdy <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_prodRdy <= (w_nextState != DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_lenLat <= '0;
            r_ovf    <= 1'b0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            if (r_state == IDLE) begin
                r_acc    <= w_prodExt;
                r_cnt    <= CNT_W'(1);
                r_lenLat <= w_lenEff;
                r_ovf    <= 1'b0;
            end else begin
                // A carry out of the top bit clamps the total; an all-ones total then stays clamped.
                if (w_addFull[ACC_W]) begin
                    r_acc <= '1;
                    r_ovf <= 1'b1;
                end else begin
                    r_acc <= w_addFull[ACC_W-1:0];
                end
                r_cnt <= w_cntInc;
            end
        end
    end

endmodule

// File: tb/tb_mac_acc.sv
// Self-checking bench for mac_acc (N=8, ACC_W=16): one table row per clock cycle,
// plus hand-written asynchronous reset sequences.
module tb_mac_acc;

    localparam int N     = 8;
    localparam int ACC_W = 16;
    localparam int CNT_W = 8;

    logic               clk;
    logic               rst_n;
    logic               clr;
    logic [CNT_W-1:0]   len;
    logic               prod_vld;
    logic [2*N-1:0]     prod;
    logic               prod_rdy;
    logic               sum_vld;
    logic [ACC_W-1:0]   sum;
    logic               ovf;
    logic               sum_rdy;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        int len;
        bit vld;
        int prod;
        bit sRdy;
        bit clr;
        bit eRdy;
        bit eVld;
        int eSum;
        bit eOvf;
    } vec_t;

    vec_t vecs[$];

    mac_acc #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .len      (len),
        .prod_vld (prod_vld),
        .prod     (prod),
        .prod_rdy (prod_rdy),
        .sum_vld  (sum_vld),
        .sum      (sum),
        .ovf      (ovf),
        .sum_rdy  (sum_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int l, bit v, int p, bit sr, bit c,
                                bit er, bit ev, int es, bit eo);
        vec_t r;
        r.len = l;  r.vld = v;  r.prod = p;  r.sRdy = sr; r.clr = c;
        r.eRdy = er; r.eVld = ev; r.eSum = es; r.eOvf = eo;
        return r;
    endfunction

    task automatic checkVal(input string tag, input int act, input int exp);
        testCount++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input bit eRdy, input bit eVld,
                               input int eSum, input bit eOvf);
        checkVal({tag, " prod_rdy"}, int'(prod_rdy), int'(eRdy));
        checkVal({tag, " sum_vld"},  int'(sum_vld),  int'(eVld));
        checkVal({tag, " sum"},      int'(sum),      eSum);
        checkVal({tag, " ovf"},      int'(ovf),      int'(eOvf));
    endtask

    task automatic applyStimulus(input vec_t v);
        len      = CNT_W'(v.len);
        prod_vld = v.vld;
        prod     = (2*N)'(v.prod);
        sum_rdy  = v.sRdy;
        clr      = v.clr;
        @(posedge clk);
        #1;
    endtask

    task automatic runRows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d", i), vecs[i].eRdy, vecs[i].eVld,
                        vecs[i].eSum, vecs[i].eOvf);
        end
    endtask

    initial begin
        // idle after reset release
        vecs.push_back(mk(0, 0, 0,     1, 0,  1, 0, 0,     0));  // 0
        // len=4: 8,32,88,132 -> 260
        vecs.push_back(mk(4, 1, 8,     1, 0,  1, 0, 8,     0));  // 1
        vecs.push_back(mk(4, 1, 32,    1, 0,  1, 0, 40,    0));  // 2
        vecs.push_back(mk(4, 1, 88,    1, 0,  1, 0, 128,   0));  // 3
        vecs.push_back(mk(4, 1, 132,   1, 0,  0, 1, 260,   0));  // 4
        vecs.push_back(mk(4, 0, 0,     1, 0,  1, 0, 260,   0));  // 5
        // len=0 treated as 1
        vecs.push_back(mk(0, 1, 28125, 1, 0,  0, 1, 28125, 0));  // 6
        vecs.push_back(mk(0, 0, 0,     1, 0,  1, 0, 28125, 0));  // 7
        // backpressure: 100+200, sum_rdy low 5 cycles, prod_vld held high
        vecs.push_back(mk(2, 1, 100,   0, 0,  1, 0, 100,   0));  // 8
        vecs.push_back(mk(2, 1, 200,   0, 0,  0, 1, 300,   0));  // 9
        vecs.push_back(mk(2, 1, 999,   0, 0,  0, 1, 300,   0));  // 10
        vecs.push_back(mk(2, 1, 999,   0, 0,  0, 1, 300,   0));  // 11
        vecs.push_back(mk(2, 1, 999,   0, 0,  0, 1, 300,   0));  // 12
        vecs.push_back(mk(2, 1, 999,   0, 0,  0, 1, 300,   0));  // 13
        vecs.push_back(mk(2, 1, 999,   0, 0,  0, 1, 300,   0));  // 14
        vecs.push_back(mk(2, 1, 999,   1, 0,  1, 0, 300,   0));  // 15 transfer
        // saturation: 65025+1000+5 -> 65535, ovf
        vecs.push_back(mk(3, 1, 65025, 1, 0,  1, 0, 65025, 0));  // 16
        vecs.push_back(mk(3, 1, 1000,  1, 0,  1, 0, 65535, 1));  // 17
        vecs.push_back(mk(3, 1, 5,     1, 0,  0, 1, 65535, 1));  // 18
        vecs.push_back(mk(3, 0, 0,     1, 0,  1, 0, 65535, 1));  // 19
        vecs.push_back(mk(1, 1, 7,     1, 0,  0, 1, 7,     0));  // 20
        vecs.push_back(mk(1, 0, 0,     1, 0,  1, 0, 7,     0));  // 21
        // gapped input, len changed mid-frame has no effect
        vecs.push_back(mk(3, 1, 10,    1, 0,  1, 0, 10,    0));  // 22
        vecs.push_back(mk(9, 0, 77,    1, 0,  1, 0, 10,    0));  // 23
        vecs.push_back(mk(9, 0, 77,    1, 0,  1, 0, 10,    0));  // 24
        vecs.push_back(mk(2, 1, 20,    1, 0,  1, 0, 30,    0));  // 25
        vecs.push_back(mk(2, 0, 77,    1, 0,  1, 0, 30,    0));  // 26
        vecs.push_back(mk(2, 1, 30,    1, 0,  0, 1, 60,    0));  // 27
        vecs.push_back(mk(2, 0, 0,     1, 0,  1, 0, 60,    0));  // 28
        // clr after 2 of 4 beats, together with a third beat
        vecs.push_back(mk(4, 1, 1,     1, 0,  1, 0, 1,     0));  // 29
        vecs.push_back(mk(4, 1, 2,     1, 0,  1, 0, 3,     0));  // 30
        vecs.push_back(mk(4, 1, 4,     1, 1,  1, 0, 0,     0));  // 31
        vecs.push_back(mk(4, 0, 0,     1, 0,  1, 0, 0,     0));  // 32
        vecs.push_back(mk(2, 1, 5,     1, 0,  1, 0, 5,     0));  // 33
        vecs.push_back(mk(2, 1, 6,     1, 0,  0, 1, 11,    0));  // 34
        vecs.push_back(mk(2, 0, 0,     1, 0,  1, 0, 11,    0));  // 35
        // frame that saturates, then rst_n mid-frame
        vecs.push_back(mk(4, 1, 65000, 1, 0,  1, 0, 65000, 0));  // 36
        vecs.push_back(mk(4, 1, 1000,  1, 0,  1, 0, 65535, 1));  // 37
        // after reset release: idle, then fresh frame 9+11
        vecs.push_back(mk(0, 0, 0,     1, 0,  1, 0, 0,     0));  // 38
        vecs.push_back(mk(2, 1, 9,     1, 0,  1, 0, 9,     0));  // 39
        vecs.push_back(mk(2, 1, 11,    1, 0,  0, 1, 20,    0));  // 40
        vecs.push_back(mk(2, 0, 0,     1, 0,  1, 0, 20,    0));  // 41
        // frame ending in DONE held by backpressure, then reset
        vecs.push_back(mk(1, 1, 42,    0, 0,  0, 1, 42,    0));  // 42
        vecs.push_back(mk(1, 1, 43,    0, 0,  0, 1, 42,    0));  // 43
        // after reset release
        vecs.push_back(mk(0, 0, 0,     1, 0,  1, 0, 0,     0));  // 44
        vecs.push_back(mk(0, 1, 3,     1, 0,  0, 1, 3,     0));  // 45

        rst_n    = 1'b0;
        clr      = 1'b0;
        len      = '0;
        prod_vld = 1'b0;
        prod     = '0;
        sum_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 1'b0, 0, 1'b0);
        rst_n = 1'b1;

        runRows(0, 37);

        rst_n = 1'b0;
        #1;
        checkOutput("async rst mid-frame", 1'b0, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held in rst", 1'b0, 1'b0, 0, 1'b0);
        rst_n = 1'b1;

        runRows(38, 43);

        rst_n = 1'b0;
        #1;
        checkOutput("async rst in DONE", 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        runRows(44, 45);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
